fifo_rptr_empty_ctrl: RTL and testbench
=======================================

Name: fifo_rptr_empty_ctrl

Overview:
Read-side pointer and empty controller for the team's dual-clock FIFO; it sequences read-port accesses.
- Keeps the binary read pointer and publishes its Gray form to the write domain.
- Synchronizes the write domain's Gray pointer and converts it back to binary.
- Produces empty, almost-empty, occupancy and underflow-error flags, all registered in the read clock domain.

Parameters:
ADDRSIZE, 8, FIFO depth is 2^ADDRSIZE; pointers are ADDRSIZE+1 bits wide (one wrap bit).
SYNC_STAGES, 2, flop stages on the incoming write pointer; legal values are 2 or more.
AEMPTY_THRESH, 4, raempty asserts when occupancy is at or below this value.

Ports:
rclk  input  1  read-domain clock.
rrst  input  1  reset, asynchronous and active-high.
rinc  input  1  read request; honoured only when rempty=0.
wptr_gray  input  ADDRSIZE+1  write pointer in Gray code, asynchronous to rclk.
raddr  output  ADDRSIZE  RAM read address.
rptr_gray  output  ADDRSIZE+1  registered Gray read pointer, sent to the write domain.
rempty  output  1  FIFO empty.
raempty  output  1  occupancy is at or below AEMPTY_THRESH.
rlevel  output  ADDRSIZE+1  occupancy in words, range 0..2^ADDRSIZE.
rerr  output  1  sticky underflow flag.

Behaviour:
- All state is on the rclk rising edge with asynchronous reset on rrst=1.
- Reset values: rbin=0, rptr_gray=0, every sync stage=0, rempty=1, raempty=1, rlevel=0, rerr=0. raddr is therefore 0.
- Read-pointer update:
  - rd_ok = rinc & ~rempty.
  - rbin_next = rbin + rd_ok, modulo 2^(ADDRSIZE+1).
  - rgray_next = rbin_next ^ (rbin_next >> 1).
  - rbin and rptr_gray both load on every edge.
- raddr = rbin[ADDRSIZE-1:0], driven combinationally from the register. Data for the current read is at raddr in the same cycle rinc is asserted.
- Synchronizer:
  - wptr_gray passes through SYNC_STAGES flops; the last stage is wq_gray.
  - No logic between stages; only Gray-coded values cross the boundary.
- Binary conversion: wq_bin = Gray-to-binary of wq_gray, pure combinational, width ADDRSIZE+1.
- Next-state flags:
  - rempty <= (rgray_next == wq_gray).
  - lvl_next = (wq_bin - rbin_next) mod 2^(ADDRSIZE+1); rlevel <= lvl_next.
  - raempty <= (lvl_next <= AEMPTY_THRESH).
- rerr is set when rinc & rempty. It is cleared only by rrst.
- Latency:
  - A new stable wptr_gray reaches rempty/rlevel SYNC_STAGES+1 rclk edges later.
  - A read deasserts nothing early. Flags are pessimistic: rempty may stay high late but never drops early.
- Boundary conditions:
  - Read while empty: pointer holds, rempty stays 1, rerr is set.
  - Read on the last word: rempty=1 on the next edge, even if rinc is held.
  - Read and synchronized-pointer advance in the same cycle: both feed one next-state computation, so the level changes by (writes seen − 1).
  - Wrap: after 2^(ADDRSIZE+1) reads rbin returns to 0. The wrap bit distinguishes full (level = 2^ADDRSIZE) from empty (level 0).
  - rrst mid-operation: all outputs return to reset values immediately and asynchronously. The write side must be reset concurrently; a write pointer still nonzero after reset shows up as occupancy.

Decomposition:
- Package fifo_ptr_pkg holds:
  - a constant function for pointer width (ADDRSIZE+1);
  - a bin2gray function;
  - the synchronizer-stage minimum (2).
- One sub-module instance: the team's existing gray2bin converter, with its ADDRSIZE parameter set to ADDRSIZE+1, producing wq_bin.
- The synchronizer and flags stay inline.

Test Plan:
1. Reset and idle (ADDRSIZE=3, AEMPTY_THRESH=2): rrst pulse, wptr_gray=0, rinc=1 for 3 cycles -> rempty=1, raempty=1, rlevel=0, raddr=0, rptr_gray=0, rerr=1 after the first edge.
2. Fill latency: wptr_gray steps 0→1→3→2 (binary 1,2,3), one step per rclk -> rempty falls exactly 3 edges after the first step; rlevel reaches 3; raempty falls only once level > 2.
3. Drain: level 3, rinc=1 held -> raddr 0,1,2; rptr_gray 1,3,2; rempty=1 after the third read; the pointer stays at binary 3; rerr stays 0 if rinc drops when rempty rises.
4. Full-depth and wrap: wptr binary 8 (Gray 1100), rptr 0 -> rlevel=8, rempty=0. Then read 16 words total across two fills -> rbin wraps to 0 and rptr_gray returns to 0.
5. Simultaneous events: level 2, rinc=1 in the same cycle the synchronized pointer advances by 1 -> rlevel stays 2, rempty stays 0.
6. Asynchronous reset mid-drain: assert rrst between edges while level=5 -> outputs reach reset values before the next rclk edge; after release with wptr_gray=0, rempty=1.

Source files
------------

// File: rtl/fifo_ptr_pkg.sv
// ---------------------------------------------------------------------------
// fifo_ptr_pkg
// Shared helpers for the dual-clock FIFO pointer logic.
//   ptr_width()      : pointer width for a given address size (one wrap bit).
//   bin2gray()       : binary to reflected-Gray conversion, generic up to
//                      PTR_MAX_W bits (callers zero-extend and truncate).
//   SYNC_STAGES_MIN  : fewest flops allowed on a pointer synchronizer.
// ---------------------------------------------------------------------------
package fifo_ptr_pkg;

  localparam int PTR_MAX_W       = 32;
  localparam int SYNC_STAGES_MIN = 2;

  // Pointer carries one extra bit so full and empty can be told apart.
  function automatic int ptr_width(input int addrsize);
    return addrsize + 1;
  endfunction

  // Input must be zero-extended so the top Gray bit equals the top binary bit.
  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage : fifo_ptr_pkg

// File: rtl/fifo_rptr_empty_ctrl_gray2bin.sv
// ---------------------------------------------------------------------------
// fifo_rptr_empty_ctrl_gray2bin
// Purely combinational Gray-to-binary converter.
//   gray : input  [ADDRSIZE-1:0]  reflected-Gray code word
//   bin  : output [ADDRSIZE-1:0]  equivalent binary value
// Note: ADDRSIZE here is the full word width, not a FIFO address size.
// ---------------------------------------------------------------------------
module fifo_rptr_empty_ctrl_gray2bin #(
  parameter int ADDRSIZE = 9
) (
  input  logic [ADDRSIZE-1:0] gray,
  output logic [ADDRSIZE-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at and above its position.
  for (genvar gi = 0; gi < ADDRSIZE; gi++) begin : g_bit
    assign bin[gi] = ^gray[ADDRSIZE-1:gi];
  end

endmodule : fifo_rptr_empty_ctrl_gray2bin

// File: rtl/fifo_rptr_empty_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_rptr_empty_ctrl
// Read-side pointer and empty/occupancy controller of the dual-clock FIFO.
// Ports:
//   rclk       in   read-domain clock
//   rrst       in   asynchronous active-high reset
//   rinc       in   read request, honoured only while rempty=0
//   wptr_gray  in   [ADDRSIZE:0]   write pointer (Gray), asynchronous to rclk
//   raddr      out  [ADDRSIZE-1:0] RAM read address (low bits of read pointer)
//   rptr_gray  out  [ADDRSIZE:0]   registered Gray read pointer to write side
//   rempty     out  FIFO empty
//   raempty    out  occupancy <= AEMPTY_THRESH
//   rlevel     out  [ADDRSIZE:0]   occupancy in words, 0..2^ADDRSIZE
//   rerr       out  sticky underflow (read attempted while empty)
// ---------------------------------------------------------------------------
module fifo_rptr_empty_ctrl
  import fifo_ptr_pkg::*;
#(
  parameter int ADDRSIZE      = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   wptr_gray,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr_gray,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                rerr
);

  localparam int          PW    = ptr_width(ADDRSIZE);
  localparam logic [31:0] AE_TH = AEMPTY_THRESH;

  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync
    $error("fifo_rptr_empty_ctrl: SYNC_STAGES must be at least 2");
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [PW-1:0] rbin_q,  rbin_d;
  logic [PW-1:0] rgray_q, rgray_d;
  logic [PW-1:0] wsync_q [SYNC_STAGES];
  logic          rempty_q, rempty_d;
  logic          raempty_q, raempty_d;
  logic [PW-1:0] rlevel_q, lvl_d;
  logic          rerr_q, rerr_d;

  logic [PW-1:0] wq_gray;
  logic [PW-1:0] wq_bin;
  logic          rd_ok;

  // -------------------------------------------------------------------------
  // Write-pointer synchronizer: straight flop chain, Gray values only, so at
  // most one bit is in flight and a metastable sample resolves to either the
  // old or the new pointer.
  // -------------------------------------------------------------------------
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        wsync_q[i] <= '0;
      end
    end else begin
      wsync_q[0] <= wptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        wsync_q[i] <= wsync_q[i-1];
      end
    end
  end

  assign wq_gray = wsync_q[SYNC_STAGES-1];

  fifo_rptr_empty_ctrl_gray2bin #(
    .ADDRSIZE (PW)
  ) u_wq_gray2bin (
    .gray (wq_gray),
    .bin  (wq_bin)
  );

  // -------------------------------------------------------------------------
  // Next-state logic. The post-read pointer is used for every flag so a read
  // on the last word raises rempty on the very next edge; the synchronized
  // write pointer is always stale, which keeps the flags pessimistic.
  // -------------------------------------------------------------------------
  always_comb begin
    rd_ok     = rinc & ~rempty_q;
    rbin_d    = rbin_q + PW'(rd_ok);
    rgray_d   = PW'(bin2gray(PTR_MAX_W'(rbin_d)));
    rempty_d  = (rgray_d == wq_gray);
    lvl_d     = wq_bin - rbin_d;
    raempty_d = (32'(lvl_d) <= AE_TH);
    rerr_d    = rerr_q | (rinc & rempty_q);
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin_q    <= '0;
      rgray_q   <= '0;
      rempty_q  <= 1'b1;
      raempty_q <= 1'b1;
      rlevel_q  <= '0;
      rerr_q    <= 1'b0;
    end else begin
      rbin_q    <= rbin_d;
      rgray_q   <= rgray_d;
      rempty_q  <= rempty_d;
      raempty_q <= raempty_d;
      rlevel_q  <= lvl_d;
      rerr_q    <= rerr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign raddr     = rbin_q[ADDRSIZE-1:0];
  assign rptr_gray = rgray_q;
  assign rempty    = rempty_q;
  assign raempty   = raempty_q;
  assign rlevel    = rlevel_q;
  assign rerr      = rerr_q;

endmodule : fifo_rptr_empty_ctrl

// File: tb/tb_fifo_rptr_empty_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_rptr_empty_ctrl
// Drives a small instance (ADDRSIZE=3, SYNC_STAGES=2, AEMPTY_THRESH=2) with
// directed scenarios followed by random traffic. Expected outputs come from
// a model that tracks total words written and read as plain integers plus a
// short history of the write count standing in for the crossing delay.
// ---------------------------------------------------------------------------
module tb_fifo_rptr_empty_ctrl;

  localparam int AS    = 3;
  localparam int SS    = 2;
  localparam int AET   = 2;
  localparam int DEPTH = 1 << AS;
  localparam int MODP  = 2 * DEPTH;

  logic          rclk = 1'b0;
  logic          rrst = 1'b0;
  logic          rinc = 1'b0;
  logic [AS:0]   wptr_gray = '0;
  logic [AS-1:0] raddr;
  logic [AS:0]   rptr_gray;
  logic          rempty, raempty, rerr;
  logic [AS:0]   rlevel;

  fifo_rptr_empty_ctrl #(
    .ADDRSIZE      (AS),
    .SYNC_STAGES   (SS),
    .AEMPTY_THRESH (AET)
  ) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .rinc      (rinc),
    .wptr_gray (wptr_gray),
    .raddr     (raddr),
    .rptr_gray (rptr_gray),
    .rempty    (rempty),
    .raempty   (raempty),
    .rlevel    (rlevel),
    .rerr      (rerr)
  );

  always #5 rclk = ~rclk;

  // ---- reference model ----------------------------------------------------
  int wcnt;            // words written so far (write side)
  int reads;           // words read so far
  int hist [SS];       // write count as seen 1..SS edges ago
  int m_level;
  bit m_empty, m_aempty, m_err;

  int checks = 0;
  int passes = 0;
  int txn    = 0;

  function automatic int gray_of(input int v);
    int b;
    b = v % MODP;
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    wcnt     = 0;
    reads    = 0;
    for (int i = 0; i < SS; i++) hist[i] = 0;
    m_level  = 0;
    m_empty  = 1'b1;
    m_aempty = 1'b1;
    m_err    = 1'b0;
  endtask

  // Called at each rising edge with the inputs that were applied.
  task automatic model_edge(input bit ri, input int wc);
    bit rd;
    int seen;
    rd   = ri && !m_empty;
    if (ri && m_empty) m_err = 1'b1;
    if (rd) reads = reads + 1;
    seen     = hist[SS-1];
    m_level  = ((seen - reads) % MODP + MODP) % MODP;
    m_empty  = (m_level == 0);
    m_aempty = (m_level <= AET);
    for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = wc;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s txn=%0d observed=%0d expected=%0d", tag, txn, obs, exp);
  endtask

  task automatic chk_all(input string ctx);
    chk({ctx, ":rempty"},    int'(rempty),    int'(m_empty));
    chk({ctx, ":raempty"},   int'(raempty),   int'(m_aempty));
    chk({ctx, ":rlevel"},    int'(rlevel),    m_level);
    chk({ctx, ":raddr"},     int'(raddr),     reads % DEPTH);
    chk({ctx, ":rptr_gray"}, int'(rptr_gray), gray_of(reads));
    chk({ctx, ":rerr"},      int'(rerr),      int'(m_err));
  endtask

  // One rclk cycle: drive on falling edge, model on rising edge, sample after.
  task automatic step(input bit ri, input string ctx);
    @(negedge rclk);
    rinc      = ri;
    wptr_gray = (AS+1)'(gray_of(wcnt));
    @(posedge rclk);
    model_edge(ri, wcnt);
    #1;
    txn++;
    $display("txn %0d %s rinc=%0b wcnt=%0d | rempty=%0b raempty=%0b rlevel=%0d raddr=%0d rptr_gray=%0h rerr=%0b",
             txn, ctx, ri, wcnt, rempty, raempty, rlevel, raddr, rptr_gray, rerr);
    chk_all(ctx);
  endtask

  task automatic do_reset();
    @(negedge rclk);
    rrst      = 1'b1;
    rinc      = 1'b0;
    wptr_gray = '0;
    model_reset();
    @(posedge rclk);
    @(negedge rclk);
    rrst = 1'b0;
    chk_all("reset");
  endtask

  task automatic write_one(input string ctx);
    if (wcnt - reads < DEPTH) wcnt++;
    step(1'b0, ctx);
  endtask

  initial begin
    model_reset();

    // 1. Reset and idle: reads while empty only set the sticky error.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, "idle_read");
    chk("underflow_sticky", int'(rerr), 1);

    // 2. Fill latency: three writes, one per cycle.
    do_reset();
    write_one("fill");
    write_one("fill");
    chk("empty_before_latency", int'(rempty), 1);
    write_one("fill");
    chk("empty_falls_3rd_edge", int'(rempty), 0);
    chk("level_after_1", int'(rlevel), 1);
    step(1'b0, "fill_settle");
    chk("aempty_at_2", int'(raempty), 1);
    step(1'b0, "fill_settle");
    chk("level_3", int'(rlevel), 3);
    chk("aempty_above_2", int'(raempty), 0);

    // 3. Drain with rinc held, dropped once empty shows.
    for (int i = 0; i < 3; i++) step(1'b1, "drain");
    chk("drain_empty", int'(rempty), 1);
    step(1'b0, "drain_stop");
    chk("drain_no_err", int'(rerr), 0);
    chk("drain_ptr_held", int'(rptr_gray), 2);

    // 4. Full depth, then wrap the pointer via two full fills.
    do_reset();
    for (int i = 0; i < DEPTH; i++) write_one("full_fill");
    for (int i = 0; i < SS + 1; i++) step(1'b0, "full_settle");
    chk("full_level", int'(rlevel), DEPTH);
    chk("full_not_empty", int'(rempty), 0);
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 40 && reads < DEPTH * (pass + 1); i++)
        step(!m_empty, "wrap_read");
      if (pass == 0) begin
        for (int i = 0; i < DEPTH; i++) write_one("wrap_fill");
        for (int i = 0; i < SS + 1; i++) step(1'b0, "wrap_settle");
      end
    end
    chk("wrap_reads", reads, 2 * DEPTH);
    chk("wrap_gray_zero", int'(rptr_gray), 0);

    // 5. Read in the same edge the synchronized pointer advances.
    do_reset();
    write_one("sim_fill");
    write_one("sim_fill");
    for (int i = 0; i < SS + 1; i++) step(1'b0, "sim_settle");
    write_one("sim_write");
    step(1'b0, "sim_wait");
    step(1'b1, "sim_read");
    chk("sim_level_kept", int'(rlevel), 2);
    chk("sim_not_empty", int'(rempty), 0);

    // 6. Asynchronous reset mid-drain.
    do_reset();
    for (int i = 0; i < 6; i++) write_one("ar_fill");
    for (int i = 0; i < SS + 1; i++) step(1'b0, "ar_settle");
    step(1'b1, "ar_read");
    chk("ar_level5", int'(rlevel), 5);
    @(negedge rclk);
    rinc = 1'b1;
    @(posedge rclk);
    model_edge(1'b1, wcnt);
    #3;
    rrst      = 1'b1;
    wptr_gray = '0;
    #1;
    model_reset();
    chk_all("async_reset");
    @(negedge rclk);
    rrst = 1'b0;
    rinc = 1'b0;
    step(1'b0, "after_reset");
    chk("after_reset_empty", int'(rempty), 1);

    // 7. Random traffic with single-step Gray write pointer.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1 && (wcnt - reads) < DEPTH) wcnt++;
      step(($urandom_range(0, 3) != 0) && !(m_empty && $urandom_range(0, 7) != 0), "random");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_fifo_rptr_empty_ctrl
